// File: rtl/mac_dot_sequencer.sv
// rtl/mac_dot_sequencer.sv - buffers A/B operand vectors and sequences one mac_128 through a dot product.
// Optional overflow shadow accumulator enabled by defining MAC_SEQ_OVF_EN.
module mac_dot_sequencer #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 39,
    parameter int DEPTH     = 128,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [AW-1:0]        wr_addr,
    input  logic [IN_WIDTH-1:0]  wr_data,
    input  logic                 start,
    input  logic [AW:0]          len,
    output logic                 busy,
    output logic                 err,
    output logic                 mac_acc_rst,
    output logic [IN_WIDTH-1:0]  mac_a,
    output logic [IN_WIDTH-1:0]  mac_b,
    input  logic [ACC_WIDTH-1:0] mac_result,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_WIDTH-1:0] res_data,
    output logic                 res_ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN1,
        S_DRAIN2,
        S_OUT
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [AW:0]          r_len;
    logic [AW:0]          w_len_nxt;
    logic [AW:0]          r_idx;
    logic [AW:0]          w_idx_nxt;
    logic                 r_busy;
    logic                 r_err;
    logic                 w_err_nxt;
    logic                 r_acc_rst;
    logic                 w_acc_rst_nxt;
    logic [IN_WIDTH-1:0]  r_a;
    logic [IN_WIDTH-1:0]  w_a_nxt;
    logic [IN_WIDTH-1:0]  r_b;
    logic [IN_WIDTH-1:0]  w_b_nxt;
    logic                 r_res_valid;
    logic                 w_res_valid_nxt;
    logic [ACC_WIDTH-1:0] r_res_data;
    logic [ACC_WIDTH-1:0] w_res_data_nxt;
    logic                 w_len_bad;

    logic [IN_WIDTH-1:0]  r_buf_a [DEPTH];
    logic [IN_WIDTH-1:0]  r_buf_b [DEPTH];

    assign w_len_bad = (len == '0) || (len > (AW+1)'(DEPTH));

    // Operand buffers carry no reset; host rewrites them before every operation.
    always_ff @(posedge clk) begin
        if (wr_en && (r_state == S_IDLE)) begin
            if (wr_sel) begin
                r_buf_b[wr_addr] <= wr_data;
            end else begin
                r_buf_a[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_idx_nxt       = r_idx;
        w_err_nxt       = 1'b0;
        w_acc_rst_nxt   = 1'b0;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_res_valid_nxt = r_res_valid;
        w_res_data_nxt  = r_res_data;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_len_bad) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_len_nxt     = len;
                        w_idx_nxt     = '0;
                        w_acc_rst_nxt = 1'b1;
                        w_state_nxt   = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                w_a_nxt     = r_buf_a[0];
                w_b_nxt     = r_buf_b[0];
                w_idx_nxt   = (AW+1)'(1);
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                // r_idx == r_len means A[N-1] has just had its cycle on the bus.
                if (r_idx == r_len) begin
                    w_a_nxt     = '0;
                    w_b_nxt     = '0;
                    w_state_nxt = S_DRAIN1;
                end else begin
                    w_a_nxt   = r_buf_a[r_idx[AW-1:0]];
                    w_b_nxt   = r_buf_b[r_idx[AW-1:0]];
                    w_idx_nxt = r_idx + (AW+1)'(1);
                end
            end
            S_DRAIN1: begin
                w_state_nxt = S_DRAIN2;
            end
            S_DRAIN2: begin
                w_res_data_nxt  = mac_result;
                w_res_valid_nxt = 1'b1;
                w_state_nxt     = S_OUT;
            end
            S_OUT: begin
                if (res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_acc_rst   <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_idx       <= w_idx_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_err       <= w_err_nxt;
            r_acc_rst   <= w_acc_rst_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_data  <= w_res_data_nxt;
        end
    end

`ifdef MAC_SEQ_OVF_EN
    logic [ACC_WIDTH:0]    r_shadow;
    logic                  r_res_ovf;
    logic [2*IN_WIDTH-1:0] w_prod;

    assign w_prod = {{IN_WIDTH{1'b0}}, r_a} * {{IN_WIDTH{1'b0}}, r_b};

    // Shadow sum tracks the MAC one bit wider so a wrap of res_data is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_res_ovf <= 1'b0;
        end else begin
            if (r_state == S_CLEAR) begin
                r_shadow <= '0;
            end else if (r_state == S_STREAM) begin
                r_shadow <= r_shadow + (ACC_WIDTH+1)'(w_prod);
            end
            if (r_state == S_DRAIN2) begin
                r_res_ovf <= r_shadow[ACC_WIDTH];
            end else if ((r_state == S_OUT) && res_ready) begin
                r_res_ovf <= 1'b0;
            end
        end
    end

    assign res_ovf = r_res_ovf;
`else
    assign res_ovf = 1'b0;
`endif

    assign busy        = r_busy;
    assign err         = r_err;
    assign mac_acc_rst = r_acc_rst;
    assign mac_a       = r_a;
    assign mac_b       = r_b;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;

endmodule
